// File: rtl/sd_emmc_axi_pkg.sv
// Shared definitions for the SD/eMMC DMA AXI4 memory responder:
// response codes, FSM state encodings and address-decode helpers.
package sd_emmc_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  // Word offset of a byte address from the RAM base; bits [1:0] are dropped.
  function automatic logic [31:0] word_off(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] base,
                                         input int unsigned depth);
    return (addr >= base) && (((addr - base) >> 2) < depth);
  endfunction

endpackage

// File: rtl/sd_emmc_axi_slave_ram.sv
// Simple dual-port RAM: byte-enable write port, registered read port.
module sd_emmc_axi_slave_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  // NOTE: the array has no reset so it maps onto block RAM and keeps its
  // contents across a controller reset.
  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: non-blocking writes mean a same-cycle read of the written word
  // samples the old contents, which is the intended collision behaviour.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sd_emmc_dma_axi_slave.sv
// AXI4 memory responder for the SD/eMMC DMA master: single-beat writes,
// INCR read bursts served back-to-back via lookahead reads and a 2-entry buffer.
module sd_emmc_dma_axi_slave
  import sd_emmc_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned MAX_BURST   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  input  logic        wlast,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  output logic [15:0] wr_count,
  output logic [15:0] rd_burst_count
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // ---------------- write path ----------------
  w_state_t    w_state;
  logic [31:0] w_addr;
  logic        w_in_range;
  logic        ram_we;

  assign w_in_range = addr_in_range(w_addr, BASE_ADDR, DEPTH_WORDS);
  assign ram_we     = wvalid && wready && w_in_range;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state  <= W_IDLE;
      w_addr   <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_count <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          awready <= 1'b1;
          if (awready && awvalid) begin
            awready <= 1'b0;
            wready  <= 1'b1;
            w_addr  <= awaddr;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            wready   <= 1'b0;
            bvalid   <= 1'b1;
            bresp    <= !w_in_range ? RESP_DECERR : (!wlast ? RESP_SLVERR : RESP_OKAY);
            wr_count <= wr_count + 16'd1;
            w_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  r_state_t    r_state;
  logic [31:0] r_addr;
  logic [8:0]  r_left;
  logic        r_ovf;
  logic        pop;
  logic [2:0]  occ_after;

  // Beat fetched last cycle (p_*) and one skid entry behind the output register.
  logic        p_valid, p_last;
  logic [1:0]  p_resp;
  logic [31:0] p_data;
  logic        s_valid, s_last;
  logic [1:0]  s_resp;
  logic [31:0] s_data;

  logic [31:0] cur_addr;
  logic [8:0]  cur_left;
  logic        cur_ovf;
  logic        rd_en;
  logic [1:0]  issue_resp;
  logic [31:0] ram_q;

  assign pop       = rvalid && rready;
  assign occ_after = 3'(rvalid) + 3'(s_valid) + 3'(p_valid) - 3'(pop);

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    cur_addr = r_addr;
    cur_left = r_left;
    cur_ovf  = r_ovf;
    rd_en    = 1'b0;
    if (r_state == R_IDLE) begin
      cur_addr = araddr;
      cur_left = {1'b0, arlen} + 9'd1;
      cur_ovf  = ({1'b0, arlen} >= 9'(MAX_BURST));
      rd_en    = arready && arvalid;
    end else begin
      rd_en = (r_left != 9'd0) && (occ_after < 3'd2);
    end
  end

  assign issue_resp = cur_ovf ? RESP_SLVERR :
                      (addr_in_range(cur_addr, BASE_ADDR, DEPTH_WORDS) ? RESP_OKAY : RESP_DECERR);
  assign p_data     = (p_resp == RESP_OKAY) ? ram_q : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state        <= R_IDLE;
      r_addr         <= '0;
      r_left         <= '0;
      r_ovf          <= 1'b0;
      arready        <= 1'b0;
      rvalid         <= 1'b0;
      rlast          <= 1'b0;
      rresp          <= RESP_OKAY;
      rdata          <= '0;
      p_valid        <= 1'b0;
      p_last         <= 1'b0;
      p_resp         <= RESP_OKAY;
      s_valid        <= 1'b0;
      s_last         <= 1'b0;
      s_resp         <= RESP_OKAY;
      s_data         <= '0;
      rd_burst_count <= '0;
    end else begin
      p_valid <= rd_en;
      if (rd_en) begin
        p_resp <= issue_resp;
        p_last <= (cur_left == 9'd1);
        r_addr <= cur_addr + 32'd4;
        r_left <= cur_left - 9'd1;
        r_ovf  <= cur_ovf;
      end

      if (!rvalid || pop) begin
        if (s_valid) begin
          rvalid  <= 1'b1;
          rdata   <= s_data;
          rresp   <= s_resp;
          rlast   <= s_last;
          s_valid <= p_valid;
          s_data  <= p_data;
          s_resp  <= p_resp;
          s_last  <= p_last;
        end else if (p_valid) begin
          rvalid <= 1'b1;
          rdata  <= p_data;
          rresp  <= p_resp;
          rlast  <= p_last;
        end else begin
          rvalid <= 1'b0;
          rlast  <= 1'b0;
        end
      end else if (p_valid) begin
        s_valid <= 1'b1;
        s_data  <= p_data;
        s_resp  <= p_resp;
        s_last  <= p_last;
      end

      case (r_state)
        R_IDLE: begin
          arready <= 1'b1;
          if (arready && arvalid) begin
            arready <= 1'b0;
            r_state <= R_FETCH;
          end
        end
        R_FETCH: r_state <= R_DATA;
        R_DATA: begin
          if (pop && rlast) begin
            arready        <= 1'b1;
            rd_burst_count <= rd_burst_count + 16'd1;
            r_state        <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  sd_emmc_axi_slave_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (AW'(word_off(w_addr, BASE_ADDR))),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (rd_en),
    .raddr (AW'(word_off(cur_addr, BASE_ADDR))),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_sd_emmc_dma_axi_slave.sv
// Directed bench for sd_emmc_dma_axi_slave with a read-beat scoreboard.
module tb_sd_emmc_dma_axi_slave;

  localparam logic [31:0] TB_BASE  = 32'h0000_0000;
  localparam int unsigned TB_DEPTH = 1024;
  localparam int unsigned TB_MAXB  = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wlast, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [15:0] wr_count, rd_burst_count;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] model [TB_DEPTH];
  logic [15:0] exp_wr, exp_rd;
  int          n_tests, n_fail, beats_seen;
  logic        stall_q;
  logic [31:0] held_data;
  logic [1:0]  held_resp;
  logic        held_last;

  always #5 clock = ~clock;

  sd_emmc_dma_axi_slave #(
    .BASE_ADDR(TB_BASE), .DEPTH_WORDS(TB_DEPTH), .MAX_BURST(TB_MAXB)
  ) dut (
    .clock(clock), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .wr_count(wr_count), .rd_burst_count(rd_burst_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic bit inr(input logic [31:0] a);
    return (a >= TB_BASE) && (((a - TB_BASE) >> 2) < TB_DEPTH);
  endfunction

  // Read monitor: pops the scoreboard on each R handshake, checks stall stability.
  always @(negedge clock) begin
    if (reset) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_rvalid", 32'(rvalid), 32'd1);
        check("stall_rdata", rdata, held_data);
        check("stall_rresp", 32'(rresp), 32'(held_resp));
        check("stall_rlast", 32'(rlast), 32'(held_last));
      end
      if (rvalid && rready) begin
        if (sb.size() == 0) begin
          check("unexpected_beat", 32'(sb.size()), 32'd1);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check("rdata", rdata, e.data);
          check("rresp", 32'(rresp), 32'(e.resp));
          check("rlast", 32'(rlast), 32'(e.last));
          beats_seen++;
        end
      end
      stall_q   = rvalid && !rready;
      held_data = rdata;
      held_resp = rresp;
      held_last = rlast;
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic last);
    int n;
    logic [1:0] er;
    er = !inr(addr) ? 2'b11 : (!last ? 2'b10 : 2'b00);
    awaddr  = addr;
    awvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    check("awready_wait", 32'(n < 50), 32'd1);
    tick();
    awvalid = 1'b0;
    check("wready_after_aw", 32'(wready), 32'd1);
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    exp_wr = exp_wr + 16'd1;
    if (inr(addr)) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[int'((addr - TB_BASE) >> 2)][8*b +: 8] = data[8*b +: 8];
    end
    check("bvalid_after_w", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'(er));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("awready_after_b", 32'(awready), 32'd1);
    check("wr_count", 32'(wr_count), 32'(exp_wr));
  endtask

  task automatic push_burst(input logic [31:0] addr, input logic [7:0] len);
    for (int i = 0; i <= int'(len); i++) begin
      beat_t e;
      logic [31:0] a;
      a = addr + 32'(4 * i);
      e.last = (i == int'(len));
      if (int'(len) + 1 > int'(TB_MAXB)) begin
        e.data = 32'd0; e.resp = 2'b10;
      end else if (inr(a)) begin
        e.data = model[int'((a - TB_BASE) >> 2)]; e.resp = 2'b00;
      end else begin
        e.data = 32'd0; e.resp = 2'b11;
      end
      sb.push_back(e);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input bit rnd);
    int n, k;
    araddr  = addr;
    arlen   = len;
    arvalid = 1'b1;
    rready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    check("arready_wait", 32'(n < 50), 32'd1);
    push_burst(addr, len);
    tick();
    arvalid = 1'b0;
    check("arready_busy", 32'(arready), 32'd0);
    if (!rnd) check("fetch_gap_rvalid", 32'(rvalid), 32'd0);
    tick();
    k = 1;
    if (!rnd) check("first_beat_rvalid", 32'(rvalid), 32'd1);
    rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (sb.size() != 0 && k < 600) begin
      tick();
      k++;
      rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check("burst_drained", 32'(sb.size()), 32'd0);
    if (!rnd) check("burst_cycles", 32'(k), 32'(int'(len) + 2));
    rready = 1'b0;
    exp_rd = exp_rd + 16'd1;
    check("arready_after_rlast", 32'(arready), 32'd1);
    check("rd_burst_count", 32'(rd_burst_count), 32'(exp_rd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0;
    n_tests = 0; n_fail = 0; beats_seen = 0;
    exp_wr = '0; exp_rd = '0;
    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < int'(TB_DEPTH); i++) model[i] = 32'd0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_resp", 32'({bresp, rresp}), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    check("rst_rd_count", 32'(rd_burst_count), 32'd0);
    reset = 1'b0;
    tick();
    check("awready_after_rst", 32'(awready), 32'd1);
    check("arready_after_rst", 32'(arready), 32'd1);

    // Basic write then single-beat read back.
    axi_write(32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1);
    axi_read(32'h100, 8'd0, 1'b0);

    // Preload words 0x40..0x4F, then full bursts with and without back-pressure.
    for (int i = 0; i < 16; i++) axi_write(32'h100 + 32'(4 * i), 32'hA500_0000 + 32'(i), 4'hF, 1'b1);
    axi_read(32'h100, 8'd15, 1'b0);
    axi_read(32'h100, 8'd15, 1'b1);

    // Range boundaries: top-of-RAM burst and an out-of-range write.
    axi_write(32'h0, 32'h1111_1111, 4'hF, 1'b1);
    axi_write(32'hFF8, 32'h0000_0FF8, 4'hF, 1'b1);
    axi_write(32'hFFC, 32'h0000_0FFC, 4'hF, 1'b1);
    axi_write(TB_BASE + 32'(4 * TB_DEPTH), 32'hBAD0_BAD0, 4'hF, 1'b1);
    axi_read(32'hFF8, 8'd3, 1'b0);
    axi_read(32'h0, 8'd0, 1'b0);

    // Byte strobes, missing wlast, and an oversized burst.
    axi_write(32'h200, 32'h1122_3344, 4'hF, 1'b1);
    axi_write(32'h200, 32'hAABB_CCDD, 4'b0101, 1'b1);
    axi_write(32'h204, 32'hCAFE_F00D, 4'hF, 1'b0);
    axi_read(32'h200, 8'd1, 1'b0);
    axi_read(32'h100, 8'd31, 1'b0);

    // Reset in the middle of a burst.
    araddr = 32'h100; arlen = 8'd15; arvalid = 1'b1; rready = 1'b1;
    b0 = beats_seen;
    push_burst(32'h100, 8'd15);
    tick();
    arvalid = 1'b0;
    n = 0;
    while (beats_seen < b0 + 5 && n < 100) begin tick(); n++; end
    check("mid_burst_wait", 32'(n < 100), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd0);
    check("mid_rst_rd_count", 32'(rd_burst_count), 32'd0);
    sb.delete();
    rready = 1'b0;
    exp_wr = '0; exp_rd = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    check("arready_after_mid_rst", 32'(arready), 32'd1);
    check("wr_count_after_mid_rst", 32'(wr_count), 32'd0);
    axi_read(32'h100, 8'd15, 1'b0);
    axi_read(32'h200, 8'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
